bitwise_logic_unit: RTL
=======================

Name: bitwise_logic_unit

Overview:
- Parametrised, registered successor to the two-input gate set: applies one of eight bitwise logic functions to WIDTH-bit operands, selected per transaction by an opcode.
- Valid/ready handshake on input and output, 1-cycle latency, full throughput.
- Optional accumulate mode chains results through an internal register.
- Result flags (zero, parity, popcount) for downstream control and test logic.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..64).
- CW, $clog2(WIDTH+1), popcount field width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode present.
- in_ready  output  1  unit accepts input this cycle.
- op  input  3  function select (see Behaviour).
- a  input  WIDTH  operand A (ignored when acc_en=1).
- b  input  WIDTH  operand B.
- acc_en  input  1  use the accumulator as operand A and write the result back to it.
- acc_clr  input  1  synchronous accumulator clear.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream consumes result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- parity  output  1  XOR-reduction of result.
- popcount  output  CW  number of 1 bits in result.
- acc_q  output  WIDTH  current accumulator value.

Behaviour:
- Reset (rst_n low, async, any time including mid-transaction):
  - out_valid=0, result=0, zero=1, parity=0, popcount=0, acc_q=0.
  - Pending result discarded; in_ready goes to 1 once reset is released.
- Opcode map (A = acc_en ? acc_q : a):
  - 000 A&B
  - 001 A|B
  - 010 ~(A&B)
  - 011 ~(A|B)
  - 100 A^B
  - 101 ~(A^B)
  - 110 ~B
  - 111 A (pass)
- Accept: in_fire = in_valid & in_ready.
- Ready: in_ready = ~out_valid | out_ready (combinational; a one-deep register gives full throughput).
- Output: out_fire = out_valid & out_ready.
- Latency: on in_fire at edge N, result and flags are valid from edge N; out_valid=1 after that edge.
- Register update per edge:
  - in_fire: load result, zero, parity, popcount; out_valid=1.
  - else if out_fire: out_valid=0, result and flags hold.
  - else: all hold.
  - Simultaneous out_fire and in_fire: new result loaded, out_valid stays 1, no bubble.
- Flags are computed from the combinational result and registered with it; they are never recomputed from the held register.
- Stall: while out_valid=1 and out_ready=0, result and flags are stable and in_ready=0. Inputs are not sampled.
- Accumulator:
  - On in_fire with acc_en=1: acc_q <= function result.
  - acc_en=0: acc_q unaffected.
  - acc_clr=1 (whether or not in_fire occurs): acc_q <= 0 on that edge.
  - acc_clr and in_fire with acc_en=1 on the same edge: operand A for that transaction is 0, not acc_q. acc_q <= result of f(0,B); the write-back wins over the clear. Net effect: the clear applies before the operation.
  - acc_clr with in_fire and acc_en=0: acc_q <= 0; the transaction uses input a.
  - A stalled input (in_valid=1, in_ready=0) never modifies acc_q.
- Width rules:
  - All logic ops are exactly WIDTH bits; no carries.
  - popcount is zero-extended to CW bits; WIDTH=8 gives CW=4 and a maximum value of 8.
- Undriven/X opcode: not supported; the bench keeps op defined whenever in_valid=1.

Test Plan:
- Truth table, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC with op 000..111. Results in order: 8'hC0, FC, 3F, 03, 3C, C3, 33, F0. Each appears one edge after acceptance, with out_valid=1.
- Flags: a=8'hFF, b=8'hFF, op=100 -> result 00, zero=1, parity=0, popcount=0. Then op=000 -> result FF, zero=0, parity=0, popcount=8. Then a=8'h07, op=111 -> popcount=3, parity=1.
- Backpressure: issue 3 back-to-back transactions with out_ready=0 after the first. in_ready=0 and result is held for 4 cycles. Then raising out_ready drains one result per cycle with no loss or duplication; results are checked against a scoreboard.
- Accumulate: acc_clr pulse -> acc_q=0. Then acc_en=1 with op=001 and b=01, 02, 04, 80 in turn -> acc_q = 01, 03, 07, 87. Then op=100, b=87 -> acc_q=00, zero=1.
- Simultaneous clear: acc_q=8'h55, acc_clr=1 with in_fire, acc_en=1, op=101, b=8'h0F -> result F0, acc_q=F0.
- Reset mid-operation: while out_valid=1 and stalled with acc_q=8'hAA, assert rst_n=0 between edges. Outputs clear immediately without waiting for a clock: out_valid=0, result=0, zero=1, acc_q=0. After release, the first transaction behaves normally.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit
// ------------------
// Registered bitwise logic unit. For each accepted transaction it applies one
// of eight bitwise functions to WIDTH-bit operands. It registers the result
// together with its zero, parity and popcount flags. An optional accumulate
// mode uses an internal register as operand A and writes each result back to it.
//
// The output stage is one register deep with a valid/ready handshake. It
// accepts a new input on the same edge that the current result is consumed,
// so it sustains one transaction per cycle.
//
// Parameters
//   WIDTH     operand/result width in bits (1..64)
//   CW        popcount field width, derived from WIDTH (do not override)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand/opcode present
//   in_ready  unit accepts input this cycle
//   op        function select
//   a         operand A (replaced by the accumulator when acc_en=1)
//   b         operand B
//   acc_en    use accumulator as operand A and write the result back to it
//   acc_clr   synchronous accumulator clear
//   out_valid result register holds an unconsumed result
//   out_ready downstream consumes the result
//   result    registered result
//   zero      result == 0
//   parity    XOR-reduction of result
//   popcount  number of 1 bits in result
//   acc_q     current accumulator value
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CW-1:0]    popcount,
  output logic [WIDTH-1:0] acc_q
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTB = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  function automatic logic [CW-1:0] count_ones(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             parity_q;
  logic [CW-1:0]    popcnt_q;
  logic [WIDTH-1:0] acc_r;

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res_d;

  assign in_ready = ~valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  // A clear that coincides with an accumulate transaction takes effect
  // before the operation, so operand A becomes zero rather than acc_r.
  always_comb begin
    opa = a;
    if (acc_en) begin
      opa = acc_clr ? '0 : acc_r;
    end
  end

  always_comb begin
    res_d = '0;
    case (op)
      OP_AND:  res_d = opa & b;
      OP_OR:   res_d = opa | b;
      OP_NAND: res_d = ~(opa & b);
      OP_NOR:  res_d = ~(opa | b);
      OP_XOR:  res_d = opa ^ b;
      OP_XNOR: res_d = ~(opa ^ b);
      OP_NOTB: res_d = ~b;
      OP_PASS: res_d = opa;
      default: res_d = '0;
    endcase
  end

  // Output register. The flags are derived from the combinational result
  // and loaded with it, so they always match the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      popcnt_q <= '0;
    end else if (in_fire) begin
      valid_q  <= 1'b1;
      result_q <= res_d;
      zero_q   <= (res_d == '0);
      parity_q <= ^res_d;
      popcnt_q <= count_ones(res_d);
    end else if (out_fire) begin
      valid_q  <= 1'b0;
    end
  end

  // Accumulator. The write-back takes priority over the clear. The clear has
  // already zeroed operand A for that transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (in_fire && acc_en) begin
      acc_r <= res_d;
    end else if (acc_clr) begin
      acc_r <= '0;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign popcount  = popcnt_q;
  assign acc_q     = acc_r;

endmodule
